// File: rtl/sr_pkg.sv
// Constants shared by both ends of the LSB-first serial shift link.
package sr_pkg;

   // Default word length for the link.
   localparam int unsigned SR_DEFAULT_WIDTH = 4;

   // Bit-order contract with the transmit side: the first bit on the wire is the word LSB.
   localparam bit SR_LSB_FIRST = 1'b1;

endpackage : sr_pkg

// File: rtl/sipo_shift_core.sv
// Serial assembly core: shifts qualified serial bits in LSB first and tracks the bit position.
module sipo_shift_core
   import sr_pkg::*;
#(
   parameter int unsigned WIDTH = SR_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   input  logic             sin_valid,
   input  logic             sync_clr,
   output logic [WIDTH-1:0] word,
   output logic             complete,
   output logic             busy
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] shift_reg;
   logic [CNT_W-1:0] bit_cnt;
   logic             last_bit;

   // The word including the bit sampled on this edge; only meaningful when complete is high.
   assign word     = {sin, shift_reg[WIDTH-1:1]};
   assign last_bit = (bit_cnt == LAST_BIT);
   // A re-frame on the same edge suppresses the shift, so it also suppresses completion.
   assign complete = sin_valid & ~sync_clr & last_bit;
   assign busy     = |bit_cnt;

   // Shift register and bit counter: re-frame wins over a valid bit, idle cycles hold state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_reg <= '0;
         bit_cnt   <= '0;
      end else if (sync_clr) begin
         shift_reg <= '0;
         bit_cnt   <= '0;
      end else if (sin_valid) begin
         shift_reg <= {sin, shift_reg[WIDTH-1:1]};
         bit_cnt   <= last_bit ? '0 : bit_cnt + 1'b1;
      end
   end

endmodule : sipo_shift_core

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out receiver: shift core plus a valid/ready holding register and sticky overrun.
module sipo_deserializer
   import sr_pkg::*;
#(
   parameter int unsigned WIDTH = SR_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   input  logic             sin_valid,
   input  logic             sync_clr,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             busy,
   output logic             overrun
);

   logic [WIDTH-1:0] word;
   logic             complete;
   logic             accept;

   sipo_shift_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .clk      (clk),
      .rst      (rst),
      .sin      (sin),
      .sin_valid(sin_valid),
      .sync_clr (sync_clr),
      .word     (word),
      .complete (complete),
      .busy     (busy)
   );

   assign accept = dout_valid & dout_ready;

   // Holding register and handshake: a new word loads if the slot is empty or being drained this edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout       <= '0;
         dout_valid <= 1'b0;
      end else if (complete) begin
         if (!dout_valid || accept) begin
            dout       <= word;
            dout_valid <= 1'b1;
         end
      end else if (accept) begin
         dout_valid <= 1'b0;
      end
   end

   // Sticky overrun: set when a completed word finds the slot full, cleared only by reset or re-frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun <= 1'b0;
      end else if (sync_clr) begin
         overrun <= 1'b0;
      end else if (complete && dout_valid && !accept) begin
         overrun <= 1'b1;
      end
   end

endmodule : sipo_deserializer

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer at WIDTH=4 with hand-computed expected words.
module tb_sipo_deserializer;

   logic       clk;
   logic       rst;
   logic       sin;
   logic       sin_valid;
   logic       sync_clr;
   logic [3:0] dout;
   logic       dout_valid;
   logic       dout_ready;
   logic       busy;
   logic       overrun;

   int unsigned errors;
   int unsigned checks;

   sipo_deserializer #(
      .WIDTH(4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sin       (sin),
      .sin_valid (sin_valid),
      .sync_clr  (sync_clr),
      .dout      (dout),
      .dout_valid(dout_valid),
      .dout_ready(dout_ready),
      .busy      (busy),
      .overrun   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One valid bit on the next edge; returns 1 time unit after that edge.
   task automatic send_bit(input logic b);
      @(negedge clk);
      sin       = b;
      sin_valid = 1'b1;
      @(posedge clk);
      #1;
      sin_valid = 1'b0;
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      errors     = 0;
      checks     = 0;
      rst        = 1'b1;
      sin        = 1'b0;
      sin_valid  = 1'b0;
      sync_clr   = 1'b0;
      dout_ready = 1'b0;
      #1;
      check("rst_dout", 32'(dout), 32'h0);
      check("rst_valid", 32'(dout_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_ovr", 32'(overrun), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // 1: async reset mid-word, then a clean word
      send_bit(1'b1);
      send_bit(1'b0);
      check("t1_busy_pre", 32'(busy), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      check("t1_busy_async", 32'(busy), 32'h0);
      check("t1_valid_async", 32'(dout_valid), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      check("t1_dout", 32'(dout), 32'hD);
      check("t1_valid", 32'(dout_valid), 32'h1);
      @(negedge clk);
      dout_ready = 1'b1;
      @(posedge clk);
      #1;
      check("t1_accept_valid", 32'(dout_valid), 32'h0);
      check("t1_accept_dout", 32'(dout), 32'hD);

      // 2: back-to-back bits with ready high -> valid for exactly one cycle
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      check("t2_dout", 32'(dout), 32'hD);
      check("t2_valid", 32'(dout_valid), 32'h1);
      check("t2_busy", 32'(busy), 32'h0);
      idle(1);
      check("t2_valid_drop", 32'(dout_valid), 32'h0);

      // 3: idle gaps inside the word
      send_bit(1'b1);
      check("t3_busy_b0", 32'(busy), 32'h1);
      idle(1);
      send_bit(1'b0);
      idle(2);
      check("t3_busy_gap", 32'(busy), 32'h1);
      check("t3_valid_gap", 32'(dout_valid), 32'h0);
      send_bit(1'b1);
      idle(3);
      check("t3_busy_gap3", 32'(busy), 32'h1);
      send_bit(1'b1);
      check("t3_dout", 32'(dout), 32'hD);
      check("t3_valid", 32'(dout_valid), 32'h1);
      check("t3_busy_done", 32'(busy), 32'h0);
      idle(1);
      check("t3_valid_drop", 32'(dout_valid), 32'h0);

      // 4: overrun with ready low, then re-frame clears overrun only
      @(negedge clk);
      dout_ready = 1'b0;
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      check("t4_first", 32'(dout), 32'hD);
      check("t4_ovr_pre", 32'(overrun), 32'h0);
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
      check("t4_dout_kept", 32'(dout), 32'hD);
      check("t4_ovr", 32'(overrun), 32'h1);
      check("t4_valid", 32'(dout_valid), 32'h1);
      idle(2);
      check("t4_ovr_sticky", 32'(overrun), 32'h1);
      @(negedge clk);
      sync_clr = 1'b1;
      @(posedge clk);
      #1;
      sync_clr = 1'b0;
      check("t4_ovr_clr", 32'(overrun), 32'h0);
      check("t4_valid_kept", 32'(dout_valid), 32'h1);
      check("t4_dout_clr", 32'(dout), 32'hD);

      // 5: accept on the completing edge replaces the word without overrun
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      @(negedge clk);
      dout_ready = 1'b1;
      send_bit(1'b0);
      check("t5_dout", 32'(dout), 32'h6);
      check("t5_valid", 32'(dout_valid), 32'h1);
      check("t5_ovr", 32'(overrun), 32'h0);
      idle(1);
      check("t5_drain", 32'(dout_valid), 32'h0);
      @(negedge clk);
      dout_ready = 1'b0;

      // 6: re-frame with a valid bit on the same edge, then 0,1,0,1
      send_bit(1'b1); send_bit(1'b1);
      @(negedge clk);
      sync_clr  = 1'b1;
      sin       = 1'b1;
      sin_valid = 1'b1;
      @(posedge clk);
      #1;
      sync_clr  = 1'b0;
      sin_valid = 1'b0;
      check("t6_busy_clr", 32'(busy), 32'h0);
      check("t6_valid_clr", 32'(dout_valid), 32'h0);
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      check("t6_dout", 32'(dout), 32'hA);
      check("t6_valid", 32'(dout_valid), 32'h1);
      check("t6_ovr", 32'(overrun), 32'h0);

      // accept on a re-frame edge still drains the holding register
      @(negedge clk);
      sync_clr   = 1'b1;
      dout_ready = 1'b1;
      @(posedge clk);
      #1;
      sync_clr   = 1'b0;
      dout_ready = 1'b0;
      check("t7_valid", 32'(dout_valid), 32'h0);
      check("t7_dout", 32'(dout), 32'hA);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_sipo_deserializer
